// File: rtl/m_sequence_checker.sv
// Receive-side PRBS checker: self-synchronises a local 8-bit LFSR, locks, then counts bit errors.
// Optional bit counter is built when M_SEQ_CHK_BITCNT_EN is defined; otherwise bit_count is 0.
module m_sequence_checker #(
  parameter logic [7:0]  POLY        = 8'b10001110,
  parameter int unsigned LOCK_THRESH = 16,
  parameter int unsigned WIN_LEN     = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      bit_count
);

  localparam int unsigned MatchW = $clog2(LOCK_THRESH + 1);
  localparam int unsigned WinW   = $clog2(WIN_LEN + 1);
  localparam int unsigned WErrW  = $clog2(LOSS_THRESH + 1);

  localparam logic [MatchW-1:0] LockThr = MatchW'(LOCK_THRESH);
  localparam logic [WinW-1:0]   WinLen  = WinW'(WIN_LEN);
  localparam logic [WErrW-1:0]  LossThr = WErrW'(LOSS_THRESH);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e             state_q, state_d;
  logic [7:0]         r_q, r_d;
  logic [2:0]         fill_q, fill_d;
  logic [MatchW-1:0]  match_q, match_d;
  logic [WinW-1:0]    win_q, win_d;
  logic [WErrW-1:0]   werr_q, werr_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pulse_q, pulse_d;
  logic               locked_q, locked_d;

  logic [7:0]         taps;
  logic               pred;
  logic               mismatch;
  logic [MatchW-1:0]  match_inc;
  logic [WinW-1:0]    win_inc;
  logic [WErrW-1:0]   werr_inc;

  // Tap i of the register is weighted by POLY[7-i]
  always_comb begin
    taps = '0;
    for (int i = 0; i < 8; i++) taps[i] = POLY[7-i];
  end

  assign pred      = ^(r_q & taps);
  assign mismatch  = bit_in ^ pred;
  assign match_inc = match_q + MatchW'(1);
  assign win_inc   = win_q + WinW'(1);
  assign werr_inc  = werr_q + WErrW'(mismatch);

`ifdef M_SEQ_CHK_BITCNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = err_q;
    pulse_d = 1'b0;
`ifdef M_SEQ_CHK_BITCNT_EN
    bit_cnt_d = bit_cnt_q;
`endif
    if (bit_valid) begin
      unique case (state_q)
        StHunt: begin
          r_d    = {bit_in, r_q[7:1]};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd7) begin
            state_d = StVerify;
            match_d = '0;
          end
        end
        StVerify: begin
          r_d = {bit_in, r_q[7:1]};
          // An all-zero register predicts zeros forever, so it never counts as a match
          if (!mismatch && (r_q != 8'h00)) begin
            if (match_inc == LockThr) begin
              state_d = StLocked;
              match_d = '0;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          r_d = {pred, r_q[7:1]};
`ifdef M_SEQ_CHK_BITCNT_EN
          bit_cnt_d = bit_cnt_q + 32'd1;
`endif
          if (mismatch) begin
            pulse_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
          end
          if (werr_inc == LossThr) begin
            state_d = StHunt;
            fill_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_inc == WinLen) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_inc;
            werr_d = werr_inc;
          end
        end
        default: state_d = StHunt;
      endcase
    end
    if (clear) begin
      err_d = '0;
`ifdef M_SEQ_CHK_BITCNT_EN
      bit_cnt_d = '0;
`endif
    end
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StHunt;
      r_q      <= 8'h00;
      fill_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      err_q    <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
      locked_q <= locked_d;
    end
  end

`ifdef M_SEQ_CHK_BITCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) bit_cnt_q <= '0;
    else        bit_cnt_q <= bit_cnt_d;
  end
  assign bit_count = bit_cnt_q;
`else
  assign bit_count = 32'd0;
`endif

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_m_sequence_checker.sv
// Directed bench for m_sequence_checker: a reference PRBS generator drives the checker and a
// queue of expected err_pulse values is compared one cycle after each driven bit.
module tb_m_sequence_checker;

  logic        clk;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  m_sequence_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  logic pulse_q[$];

  // Reference generator state and bench-side expectations
  logic [7:0] g;
  logic       exp_lock;
  int         lbits;
  int         exp_err;
  int         win_pos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_bc();
`ifdef M_SEQ_CHK_BITCNT_EN
    return 32'(lbits);
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic b, input logic v, input logic clr, input logic rn,
                       input logic exp_p);
    logic got;
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    clear     = clr;
    rst_n     = rn;
    pulse_q.push_back(exp_p);
    @(posedge clk);
    #1;
    got = pulse_q.pop_front();
    check("err_pulse", {31'd0, err_pulse}, {31'd0, got});
  endtask

  task automatic prbs_bit(input logic flip, input logic clr);
    logic b;
    b = g[0];
    g = {g[0] ^ g[4] ^ g[5] ^ g[6], g[7:1]};
    drive(b ^ flip, 1'b1, clr, 1'b1, flip);
    if (exp_lock) win_pos = (win_pos + 1) % 64;
    if (clr) begin
      lbits   = 0;
      exp_err = 0;
    end else if (exp_lock) begin
      lbits++;
      if (flip) exp_err++;
    end
  endtask

  task automatic idle_bit();
    drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic bench_reset_state();
    exp_lock = 1'b0;
    lbits    = 0;
    exp_err  = 0;
    win_pos  = 0;
  endtask

  task automatic lock_seq(input logic toggle, input string tag);
    for (int i = 0; i < 23; i++) begin
      prbs_bit(1'b0, 1'b0);
      if (toggle) idle_bit();
    end
    check({tag, "_locked_pre"}, {31'd0, locked}, 32'd0);
    prbs_bit(1'b0, 1'b0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd1);
    exp_lock = 1'b1;
    win_pos  = 0;
  endtask

  initial begin
    logic [31:0] bc_before;
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear     = 1'b0;
    g         = 8'hFF;
    bench_reset_state();

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    check("rst_bit_count", bit_count, 32'd0);

    // Clean stream from seed FF: lock on the 24th bit, no errors over 1000 bits
    lock_seq(1'b0, "clean");
    for (int i = 0; i < 976; i++) prbs_bit(1'b0, 1'b0);
    check("clean_err_count", {16'd0, err_count}, 32'd0);
    check("clean_bit_count", bit_count, exp_bc());
`ifdef M_SEQ_CHK_BITCNT_EN
    check("clean_bit_count_976", bit_count, 32'd976);
`endif
    check("clean_locked", {31'd0, locked}, 32'd1);

    // Single inverted bit while locked
    for (int i = 0; i < 299; i++) prbs_bit(1'b0, 1'b0);
    prbs_bit(1'b1, 1'b0);
    check("single_err_count", {16'd0, err_count}, 32'd1);
    check("single_locked", {31'd0, locked}, 32'd1);
    prbs_bit(1'b0, 1'b0);
    check("single_err_hold", {16'd0, err_count}, 32'(exp_err));

    // Clear keeps lock; clear beats a simultaneous error but the pulse still fires
    prbs_bit(1'b0, 1'b1);
    check("clear_err_count", {16'd0, err_count}, 32'd0);
    check("clear_bit_count", bit_count, exp_bc());
    check("clear_locked", {31'd0, locked}, 32'd1);
    prbs_bit(1'b1, 1'b1);
    check("clear_err_race", {16'd0, err_count}, 32'd0);
    check("clear_locked2", {31'd0, locked}, 32'd1);

    // Eight errors inside one window drop lock on the eighth
    while (win_pos != 0) prbs_bit(1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      prbs_bit(1'b1, 1'b0);
      prbs_bit(1'b0, 1'b0);
    end
    check("loss_locked_at7", {31'd0, locked}, 32'd1);
    prbs_bit(1'b1, 1'b0);
    exp_lock = 1'b0;
    check("loss_locked", {31'd0, locked}, 32'd0);
    check("loss_err_count", {16'd0, err_count}, 32'd8);
    lock_seq(1'b0, "relock");
    check("relock_err_count", {16'd0, err_count}, 32'd8);
    check("relock_bit_count", bit_count, exp_bc());

    // All-zero input never locks
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bench_reset_state();
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 23 || i == 99 || i == 199) check("zero_locked", {31'd0, locked}, 32'd0);
    end
    check("zero_err_count", {16'd0, err_count}, 32'd0);
    check("zero_bit_count", bit_count, 32'd0);

    // Alternating bit_valid: lock after 24 valid bits, invalid cycles change nothing
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bench_reset_state();
    g = 8'hFF;
    lock_seq(1'b1, "toggle");
    for (int i = 0; i < 10; i++) begin
      prbs_bit(1'b0, 1'b0);
      idle_bit();
    end
    prbs_bit(1'b1, 1'b0);
    bc_before = exp_bc();
    idle_bit();
    idle_bit();
    check("toggle_err_hold", {16'd0, err_count}, 32'd1);
    check("toggle_bc_hold", bit_count, bc_before);
    check("toggle_locked", {31'd0, locked}, 32'd1);

    // Reset while locked with errors recorded, then re-lock
    prbs_bit(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 9; i++) prbs_bit(1'b0, 1'b0);
      prbs_bit(1'b1, 1'b0);
    end
    check("pre_rst_err_count", {16'd0, err_count}, 32'd5);
    check("pre_rst_locked", {31'd0, locked}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bench_reset_state();
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    check("mid_rst_err_count", {16'd0, err_count}, 32'd0);
    check("mid_rst_bit_count", bit_count, 32'd0);
    lock_seq(1'b0, "rst_relock");
    for (int i = 0; i < 20; i++) prbs_bit(1'b0, 1'b0);
    check("rst_relock_err", {16'd0, err_count}, 32'd0);
    check("rst_relock_bc", bit_count, exp_bc());

    bit_valid = 1'b0;
    clear     = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_sequence_checker.md
Name: m_sequence_checker

Overview:
- Receive-side counterpart of the team's 8-bit m-sequence (PRBS) generator; consumes the serial PRBS bit stream at the far end of a link.
- Self-synchronises a local LFSR to the incoming stream, declares lock, then counts bit errors against a free-running local prediction.
- Drops lock on excessive error density and re-hunts automatically.
- Sits behind the channel/decoder path and feeds BER statistics to the test/status logic.

Parameters:
- POLY, 8'b10001110: feedback taps, same encoding as the generator (tap i of shift reg weighted by POLY[7-i]).
- LOCK_THRESH, 16: consecutive correct predictions required to enter LOCKED.
- WIN_LEN, 64: error-monitoring window length in checked bits while LOCKED.
- LOSS_THRESH, 8: errors within one window that force loss of lock.
- ERR_W, 16: width of error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- bit_in  in  1  received PRBS bit.
- bit_valid  in  1  bit_in qualifier; all state advances only on cycles with bit_valid=1.
- clear  in  1  synchronous clear of err_count and bit_count; does not affect lock state.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_count  out  ERR_W  saturating count of errors while LOCKED.
- bit_count  out  32  bits checked while LOCKED (see Optional Feature).

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk. On reset: state=HUNT, r=8'h00, fill/match/window/window-error counters=0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- Local register r[7:0]: r[7] newest bit, r[0] oldest. Prediction p = XOR over i of (r[i] & POLY[7-i]); default POLY gives p = r0^r4^r5^r6, matching recurrence b[n+8]=b[n]^b[n+4]^b[n+5]^b[n+6]. Shift is r <= {x, r[7:1]}.
- HUNT: each valid bit shifts r <= {bit_in, r[7:1]}, fill count increments. After the 8th valid bit, go to VERIFY with match count=0.
- VERIFY: each valid bit, compare bit_in with p, then shift in bit_in (self-synchronising). Match with r!=0 increments match count. Mismatch, or r==8'h00 (stuck-zero guard), clears match count. When match count reaches LOCK_THRESH, go to LOCKED; window and window-error counts are cleared.
- LOCKED: each valid bit shifts in p (free-run, not bit_in), so r never becomes zero. If bit_in!=p: err_pulse=1 next cycle, err_count+1 (saturating at all-ones), window-error+1. bit_count+1 per valid bit.
- Window: when window count reaches WIN_LEN, both window counters clear. If window-error reaches LOSS_THRESH at any point, go to HUNT on the same edge: fill count=0, r retained but overwritten by the fill.
- Outputs are registered. locked rises on the clock edge that consumes the LOCK_THRESH-th match. Default latency from the first valid bit is 8+16=24 valid bits. locked falls on the edge that consumes the LOSS_THRESH-th window error.
- bit_valid=0: no state, register or counter change; err_pulse=0.
- clear and an error on the same cycle: clear wins; the counter is 0 afterwards. err_pulse still fires.
- rst_n low mid-operation: immediate return to reset values on that edge; rst_n has priority over clear.

Optional Feature:
- Macro M_SEQ_CHK_BITCNT_EN.
- Defined: bit_count is a 32-bit wrapping counter as described, cleared by clear and rst_n.
- Undefined: the counter is not built; bit_count is tied to 32'd0. All other behaviour is identical.

Test Plan:
- Generator from reset (seed 8'hFF, stream 1,1,1,1,1,1,1,1,0,0,1,...) with bit_valid=1 every cycle -> locked=1 after the 24th bit; err_count=0 after 1000 bits; bit_count=976 with the macro, 0 without.
- Locked, invert bit 300 only -> exactly one err_pulse, one cycle after that bit; err_count=1; locked stays 1. Then clear=1 -> err_count=0, locked=1.
- Locked, invert 8 bits within one 64-bit window -> locked=0 after the 8th error; re-lock 24 valid bits later; err_count=8.
- All-zero input for 200 bits after reset -> locked never asserts; state stays VERIFY; err_count=0.
- bit_valid toggling 1/0 on the PRBS stream -> lock after 24 valid bits (about 48 cycles); no errors; no change in any counter on invalid cycles.
- Assert rst_n=0 for one cycle while locked with err_count=5 -> next cycle locked=0, err_count=0; re-lock after 24 valid bits.
